// File: rtl/trap_csr_file.sv
// Machine-mode trap responder and CSR file.
// Takes trap requests from the interrupt controller, saves the trap state,
// redirects the PC to the handler, and handles MRET. It also implements the
// machine CSRs mstatus, mie, mtvec, mscratch, mepc, mcause and mtval.
module trap_csr_file #(
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
    parameter int          XLEN        = 32
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            trap,
    input  logic [XLEN-1:0] mcause_in,
    input  logic [XLEN-1:0] mepc_in,
    input  logic [XLEN-1:0] mbadaddr_in,
    input  logic            mret,
    input  logic            csr_en,
    input  logic [1:0]      csr_op,
    input  logic [11:0]     csr_addr,
    input  logic [XLEN-1:0] csr_wdata,
    output logic [XLEN-1:0] csr_rdata,
    output logic            csr_valid,
    output logic            csr_err,
    output logic [XLEN-1:0] mstatus,
    output logic [XLEN-1:0] mie,
    output logic            redirect,
    output logic [XLEN-1:0] redirect_pc,
    output logic            ret,
    output logic            in_trap
);

    typedef enum logic {
        IDLE,
        TRAP
    } state_t;

    localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
    localparam logic [11:0] ADDR_MIE      = 12'h304;
    localparam logic [11:0] ADDR_MTVEC    = 12'h305;
    localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
    localparam logic [11:0] ADDR_MEPC     = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
    localparam logic [11:0] ADDR_MTVAL    = 12'h343;

    localparam logic [XLEN-1:0] MIE_MASK = 32'h0000_0888;

    state_t          state_q;
    state_t          state_d;
    logic            take_trap;
    logic            take_mret;

    // Only MIE and MPIE are real storage; MPP is hardwired to machine mode.
    logic            mstatus_mie;
    logic            mstatus_mpie;
    logic [XLEN-1:0] mie_q;
    logic [XLEN-1:0] mtvec_q;
    logic [XLEN-1:0] mscratch_q;
    logic [XLEN-1:0] mepc_q;
    logic [XLEN-1:0] mcause_q;
    logic [XLEN-1:0] mtval_q;

    logic [XLEN-1:0] csr_old;
    logic            csr_hit;
    logic [XLEN-1:0] csr_new;
    logic            csr_we;
    logic [XLEN-1:0] trap_target;

    assign mstatus = {19'b0, 2'b11, 3'b0, mstatus_mpie, 3'b0, mstatus_mie, 3'b0};
    assign mie     = mie_q;
    assign in_trap = (state_q == TRAP);

    // Next state: trap entry only from IDLE, and it beats a simultaneous MRET there;
    // in TRAP further traps are ignored and MRET returns.
    always_comb begin
        state_d   = state_q;
        take_trap = 1'b0;
        take_mret = 1'b0;
        case (state_q)
            IDLE: begin
                if (trap) begin
                    take_trap = 1'b1;
                    state_d   = TRAP;
                end else if (mret) begin
                    take_mret = 1'b1;
                end
            end
            TRAP: begin
                if (mret) begin
                    take_mret = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // CSR read mux: old value of the addressed register and whether it exists.
    always_comb begin
        csr_old = '0;
        csr_hit = 1'b1;
        case (csr_addr)
            ADDR_MSTATUS:  csr_old = mstatus;
            ADDR_MIE:      csr_old = mie_q;
            ADDR_MTVEC:    csr_old = mtvec_q;
            ADDR_MSCRATCH: csr_old = mscratch_q;
            ADDR_MEPC:     csr_old = mepc_q;
            ADDR_MCAUSE:   csr_old = mcause_q;
            ADDR_MTVAL:    csr_old = mtval_q;
            default:       csr_hit = 1'b0;
        endcase
    end

    // Read-modify-write value for RW/RS/RC; op 00 leaves the register alone.
    always_comb begin
        csr_new = csr_old;
        case (csr_op)
            2'b01:   csr_new = csr_wdata;
            2'b10:   csr_new = csr_old | csr_wdata;
            2'b11:   csr_new = csr_old & ~csr_wdata;
            default: csr_new = csr_old;
        endcase
        csr_we = csr_en && csr_hit && (csr_op != 2'b00);
    end

    // Handler address: direct uses the aligned base, vectored interrupts add 4*cause.
    always_comb begin
        trap_target = {mtvec_q[XLEN-1:2], 2'b00};
        if (mtvec_q[0] && mcause_in[XLEN-1]) begin
            trap_target = {mtvec_q[XLEN-1:2], 2'b00} + {mcause_in[XLEN-3:0], 2'b00};
        end
    end

    // CSR storage. Software writes come first so that trap entry and MRET,
    // assigned later in the block, win on the fields they touch.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mstatus_mie  <= 1'b0;
            mstatus_mpie <= 1'b0;
            mie_q        <= '0;
            mtvec_q      <= MTVEC_RESET;
            mscratch_q   <= '0;
            mepc_q       <= '0;
            mcause_q     <= '0;
            mtval_q      <= '0;
        end else begin
            if (csr_we) begin
                case (csr_addr)
                    ADDR_MSTATUS: begin
                        mstatus_mie  <= csr_new[3];
                        mstatus_mpie <= csr_new[7];
                    end
                    ADDR_MIE:      mie_q      <= csr_new & MIE_MASK;
                    ADDR_MTVEC:    mtvec_q    <= {csr_new[XLEN-1:2], 1'b0, csr_new[0]};
                    ADDR_MSCRATCH: mscratch_q <= csr_new;
                    ADDR_MEPC:     mepc_q     <= {csr_new[XLEN-1:2], 2'b00};
                    ADDR_MCAUSE:   mcause_q   <= csr_new;
                    ADDR_MTVAL:    mtval_q    <= csr_new;
                    default: ;
                endcase
            end
            if (take_trap) begin
                mepc_q       <= mepc_in;
                mcause_q     <= mcause_in;
                mtval_q      <= mbadaddr_in;
                mstatus_mpie <= mstatus_mie;
                mstatus_mie  <= 1'b0;
            end
            if (take_mret) begin
                mstatus_mie  <= mstatus_mpie;
                mstatus_mpie <= 1'b1;
            end
        end
    end

    // Registered CSR response and one-cycle redirect/return pulses.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            csr_rdata   <= '0;
            csr_valid   <= 1'b0;
            csr_err     <= 1'b0;
            redirect    <= 1'b0;
            redirect_pc <= '0;
            ret         <= 1'b0;
        end else begin
            csr_valid <= csr_en;
            csr_err   <= csr_en && !csr_hit;
            if (csr_en) begin
                csr_rdata <= csr_hit ? csr_old : '0;
            end
            redirect <= take_trap || take_mret;
            ret      <= take_mret;
            if (take_trap) begin
                redirect_pc <= trap_target;
            end else if (take_mret) begin
                redirect_pc <= mepc_q;
            end
        end
    end

endmodule

// File: tb/tb_trap_csr_file.sv
// Testbench for trap_csr_file: directed scenarios followed by random traffic,
// every cycle compared against a behavioural model of the CSR/trap rules.
module tb_trap_csr_file;

    localparam logic [31:0] MTVEC_RST = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        resetn;
    logic        trap;
    logic [31:0] mcause_in;
    logic [31:0] mepc_in;
    logic [31:0] mbadaddr_in;
    logic        mret;
    logic        csr_en;
    logic [1:0]  csr_op;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;
    logic        csr_valid;
    logic        csr_err;
    logic [31:0] mstatus;
    logic [31:0] mie;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        ret;
    logic        in_trap;

    int checks   = 0;
    int failures = 0;

    // Reference model state (architectural view of the CSRs).
    logic [31:0] m_mstatus, m_mie, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval;
    bit          m_in_trap;
    logic [31:0] e_rdata, e_rpc;
    bit          e_valid, e_err, e_redirect, e_ret;

    trap_csr_file #(.MTVEC_RESET(MTVEC_RST), .XLEN(32)) dut (
        .clk(clk), .resetn(resetn), .trap(trap), .mcause_in(mcause_in),
        .mepc_in(mepc_in), .mbadaddr_in(mbadaddr_in), .mret(mret),
        .csr_en(csr_en), .csr_op(csr_op), .csr_addr(csr_addr),
        .csr_wdata(csr_wdata), .csr_rdata(csr_rdata), .csr_valid(csr_valid),
        .csr_err(csr_err), .mstatus(mstatus), .mie(mie), .redirect(redirect),
        .redirect_pc(redirect_pc), .ret(ret), .in_trap(in_trap)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        m_mstatus  = 32'h0000_1800;
        m_mie      = 0;
        m_mtvec    = MTVEC_RST;
        m_mscratch = 0;
        m_mepc     = 0;
        m_mcause   = 0;
        m_mtval    = 0;
        m_in_trap  = 0;
        e_rdata    = 0;
        e_rpc      = 0;
        e_valid    = 0;
        e_err      = 0;
        e_redirect = 0;
        e_ret      = 0;
    endtask

    function automatic logic [32:0] modelRead(input logic [11:0] a);
        case (a)
            12'h300: return {1'b1, m_mstatus};
            12'h304: return {1'b1, m_mie};
            12'h305: return {1'b1, m_mtvec};
            12'h340: return {1'b1, m_mscratch};
            12'h341: return {1'b1, m_mepc};
            12'h342: return {1'b1, m_mcause};
            12'h343: return {1'b1, m_mtval};
            default: return 33'h0;
        endcase
    endfunction

    task automatic modelWrite(input logic [11:0] a, input logic [31:0] v);
        case (a)
            12'h300: m_mstatus  = 32'h0000_1800 | (v & 32'h0000_0088);
            12'h304: m_mie      = v & 32'h0000_0888;
            12'h305: m_mtvec    = v & ~32'h2;
            12'h340: m_mscratch = v;
            12'h341: m_mepc     = v & ~32'h3;
            12'h342: m_mcause   = v;
            12'h343: m_mtval    = v;
            default: ;
        endcase
    endtask

    // One clock of the architectural rules, using the inputs present at the edge.
    task automatic modelStep();
        logic [31:0] o_mstatus = m_mstatus;
        logic [31:0] o_mtvec   = m_mtvec;
        logic [31:0] o_mepc    = m_mepc;
        logic [32:0] r;
        logic [31:0] nv;
        bit tt, tm;
        tt = trap && !m_in_trap;
        tm = mret && !tt;
        e_valid = csr_en;
        e_err   = 0;
        if (csr_en) begin
            r       = modelRead(csr_addr);
            e_err   = !r[32];
            e_rdata = r[32] ? r[31:0] : 32'h0;
            if (r[32] && csr_op != 2'b00) begin
                if (csr_op == 2'b01)      nv = csr_wdata;
                else if (csr_op == 2'b10) nv = r[31:0] | csr_wdata;
                else                      nv = r[31:0] & ~csr_wdata;
                modelWrite(csr_addr, nv);
            end
        end
        e_redirect = tt || tm;
        e_ret      = tm;
        if (tt) begin
            m_mepc    = mepc_in;
            m_mcause  = mcause_in;
            m_mtval   = mbadaddr_in;
            m_mstatus = 32'h0000_1800 | (o_mstatus[3] ? 32'h80 : 32'h0);
            e_rpc     = (o_mtvec & ~32'h3) +
                        ((o_mtvec[0] && mcause_in[31]) ? 32'(mcause_in[30:0]) * 4 : 32'h0);
            m_in_trap = 1;
        end
        if (tm) begin
            m_mstatus = 32'h0000_1880 | (o_mstatus[7] ? 32'h8 : 32'h0);
            e_rpc     = o_mepc;
            m_in_trap = 0;
        end
    endtask

    task automatic checkOutput();
        checkVal("csr_valid", 32'(csr_valid), 32'(e_valid));
        checkVal("csr_err", 32'(csr_err), 32'(e_err));
        if (e_valid) checkVal("csr_rdata", csr_rdata, e_rdata);
        checkVal("redirect", 32'(redirect), 32'(e_redirect));
        if (e_redirect) checkVal("redirect_pc", redirect_pc, e_rpc);
        checkVal("ret", 32'(ret), 32'(e_ret));
        checkVal("in_trap", 32'(in_trap), 32'(m_in_trap));
        checkVal("mstatus", mstatus, m_mstatus);
        checkVal("mie", mie, m_mie);
    endtask

    task automatic applyStimulus(input bit t, input logic [31:0] cause, input logic [31:0] epc,
                                 input logic [31:0] bad, input bit mr, input bit en,
                                 input logic [1:0] op, input logic [11:0] addr,
                                 input logic [31:0] wd);
        @(negedge clk);
        trap = t; mcause_in = cause; mepc_in = epc; mbadaddr_in = bad; mret = mr;
        csr_en = en; csr_op = op; csr_addr = addr; csr_wdata = wd;
        @(posedge clk);
        modelStep();
        #1;
        checkOutput();
    endtask

    task automatic idle();
        applyStimulus(0, 0, 0, 0, 0, 0, 2'b00, 12'h0, 0);
    endtask

    task automatic csr(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] wd);
        applyStimulus(0, 0, 0, 0, 0, 1, op, addr, wd);
    endtask

    logic [11:0] addr_pool [9] = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341,
                                   12'h342, 12'h343, 12'h7C0, 12'h301};

    initial begin
        resetn = 0; trap = 0; mcause_in = 0; mepc_in = 0; mbadaddr_in = 0; mret = 0;
        csr_en = 0; csr_op = 0; csr_addr = 0; csr_wdata = 0;
        modelReset();
        #12;
        checkOutput();
        checkVal("rst_csr_rdata", csr_rdata, 32'h0);
        @(negedge clk);
        resetn = 1;

        // Reset values of mstatus and mtvec.
        csr(2'b00, 12'h300, 0);
        checkVal("rst_mstatus_rd", csr_rdata, 32'h0000_1800);
        csr(2'b00, 12'h305, 0);
        checkVal("rst_mtvec_rd", csr_rdata, MTVEC_RST);

        // Direct trap.
        csr(2'b01, 12'h305, 32'h200);
        csr(2'b10, 12'h300, 32'h8);
        applyStimulus(1, 32'd4, 32'h1002, 32'h1002, 0, 0, 2'b00, 12'h0, 0);
        checkVal("direct_pc", redirect_pc, 32'h200);
        checkVal("direct_mstatus", mstatus, 32'h0000_1880);
        csr(2'b00, 12'h341, 0);
        checkVal("direct_mepc", csr_rdata, 32'h1002);
        csr(2'b00, 12'h343, 0);
        applyStimulus(0, 0, 0, 0, 1, 0, 2'b00, 12'h0, 0);
        checkVal("ret_pc", redirect_pc, 32'h1002);
        idle();

        // Vectored timer interrupt and return.
        csr(2'b01, 12'h305, 32'h101);
        applyStimulus(1, 32'h8000_0007, 32'h2000, 32'h0, 0, 0, 2'b00, 12'h0, 0);
        checkVal("vect_pc", redirect_pc, 32'h11C);
        idle();
        applyStimulus(0, 0, 0, 0, 1, 0, 2'b00, 12'h0, 0);
        checkVal("vect_ret_pc", redirect_pc, 32'h2000);
        checkVal("vect_ret_mstatus", mstatus, 32'h0000_1888);
        idle();

        // CSR read-modify-write operations.
        csr(2'b01, 12'h340, 32'hF0F0);
        csr(2'b10, 12'h340, 32'h000F);
        csr(2'b11, 12'h340, 32'hF000);
        checkVal("rs_result", csr_rdata, 32'hF0FF);
        csr(2'b00, 12'h340, 0);
        checkVal("rc_result", csr_rdata, 32'h00FF);
        csr(2'b01, 12'h300, 32'hFFFF_FFFF);
        csr(2'b00, 12'h300, 0);
        checkVal("mstatus_mask", csr_rdata, 32'h0000_1888);
        csr(2'b01, 12'h7C0, 32'h1234);
        checkVal("unmapped_err", 32'(csr_err), 32'h1);

        // Collisions.
        csr(2'b01, 12'h305, 32'h400);
        applyStimulus(1, 32'd2, 32'h3000, 32'h5, 0, 0, 2'b00, 12'h0, 0);
        applyStimulus(1, 32'd3, 32'h4000, 32'h6, 0, 0, 2'b00, 12'h0, 0);
        checkVal("nested_no_redirect", 32'(redirect), 32'h0);
        csr(2'b00, 12'h341, 0);
        checkVal("nested_mepc", csr_rdata, 32'h3000);
        applyStimulus(1, 32'd5, 32'h5000, 32'h7, 1, 0, 2'b00, 12'h0, 0);
        checkVal("trap_mret_in_trap", redirect_pc, 32'h3000);
        applyStimulus(1, 32'd6, 32'h6000, 32'h8, 1, 1, 2'b01, 12'h341, 32'h7777);
        checkVal("trap_mret_idle_pc", redirect_pc, 32'h400);
        csr(2'b00, 12'h341, 0);
        checkVal("trap_mret_idle_mepc", csr_rdata, 32'h6000);

        // Asynchronous reset while in TRAP.
        @(negedge clk);
        resetn = 0;
        #1;
        modelReset();
        checkOutput();
        checkVal("midreset_rdata", csr_rdata, 32'h0);
        checkVal("midreset_pc", redirect_pc, 32'h0);
        @(negedge clk);
        resetn = 1;
        idle();

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 7) == 0, $urandom, $urandom, $urandom,
                          $urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1,
                          2'($urandom_range(0, 3)), addr_pool[$urandom_range(0, 8)],
                          $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/trap_csr_file.md
Name: trap_csr_file

Overview:
Machine-mode trap responder and CSR file for the RV32 core. Consumes the trap request, cause, EPC and bad-address outputs of the interrupt controller. Performs trap entry: saves state, updates mstatus and redirects the PC to the handler. Performs MRET return and pulses `ret` back to the interrupt controller. It also provides the mstatus/mie inputs the interrupt controller samples.

Parameters:
MTVEC_RESET, 32'h0000_0000, reset value of mtvec
XLEN, 32, data width; only 32 supported

Ports:
clk  input  1  system clock
resetn  input  1  asynchronous active-low reset
trap  input  1  trap request from interrupt controller, sampled at posedge
mcause_in  input  32  cause for pending trap
mepc_in  input  32  faulting/interrupted PC
mbadaddr_in  input  32  bad address (becomes mtval)
mret  input  1  MRET executing, 1-cycle pulse
csr_en  input  1  CSR instruction access this cycle
csr_op  input  2  00 none, 01 RW, 10 RS (set), 11 RC (clear)
csr_addr  input  12  CSR address
csr_wdata  input  32  rs1/uimm operand
csr_rdata  output  32  old CSR value, registered
csr_valid  output  1  1-cycle pulse, csr_rdata valid
csr_err  output  1  1-cycle pulse, unknown address
mstatus  output  32  current mstatus
mie  output  32  current mie
redirect  output  1  1-cycle PC redirect pulse
redirect_pc  output  32  target PC, valid with redirect
ret  output  1  1-cycle pulse on MRET completion
in_trap  output  1  high while in TRAP state

Behaviour:
- Reset (async, resetn=0):
  - mstatus=32'h0000_1800 (MPP=11).
  - mie=0, mscratch=0, mepc=0, mcause=0, mtval=0, mtvec=MTVEC_RESET.
  - All pulses 0, csr_rdata=0, state IDLE.
- CSR map:
  - 0x300 mstatus: writable bits 3 (MIE) and 7 (MPIE) only; MPP[12:11] reads 11; other bits read 0.
  - 0x304 mie: only bits 3, 7, 11 writable.
  - 0x305 mtvec: bit1 forced 0; bit0 = mode (0 direct, 1 vectored).
  - 0x340 mscratch: full 32 bits.
  - 0x341 mepc: bits[1:0] forced 0 on CSR write.
  - 0x342 mcause, 0x343 mtval: full 32 bits.
- CSR access:
  - When csr_en=1, csr_rdata <= old value and csr_valid pulses on the next cycle (1-cycle latency).
  - New value: RW = wdata; RS = old|wdata; RC = old&~wdata; op 00 = read only.
  - Unmapped address: csr_rdata <= 0, write dropped, csr_err pulses alongside csr_valid.
- FSM states IDLE, TRAP.
- IDLE + trap=1 (trap entry), same edge:
  - mepc<=mepc_in, mcause<=mcause_in, mtval<=mbadaddr_in.
  - MPIE<=MIE, MIE<=0.
  - Next cycle: redirect=1. redirect_pc = {mtvec[31:2],2'b00}, or, if mtvec[0]=1 and mcause_in[31]=1, base + 4*mcause_in[30:0] (mod 2^32).
  - State -> TRAP; in_trap=1 from the cycle after entry.
- mret=1 in either state:
  - MIE<=MPIE, MPIE<=1.
  - Next cycle: redirect=1, redirect_pc=mepc (value before any same-cycle CSR write), ret=1.
  - State -> IDLE.
- trap=1 in TRAP: ignored, no nesting; the interrupt controller must re-raise after return.
- Simultaneous events:
  - trap and mret in IDLE: trap wins, mret ignored.
  - trap and mret in TRAP: mret wins.
- CSR write to mstatus/mepc/mcause/mtval in the same cycle as trap entry or mret: hardware update wins for the fields it touches; the CSR write still updates untouched registers and csr_rdata returns the pre-edge value.
- resetn asserted mid-trap: immediate return to reset values, no redirect/ret pulse emitted.
- redirect, ret, csr_valid and csr_err are never high for more than one consecutive cycle per event.

Test Plan:
- Reset then read 0x300 -> csr_rdata=32'h0000_1800 one cycle after csr_en; csr_valid pulse; mtvec read = MTVEC_RESET.
- Direct trap:
  - Setup: mtvec=0x200, mstatus.MIE=1; trap with mcause_in=4, mepc_in=0x1002, mbadaddr_in=0x1002.
  - Response: next cycle redirect=1, redirect_pc=0x200; mepc=0x1002, mtval=0x1002, MIE=0, MPIE=1, in_trap=1.
- Vectored timer:
  - Setup: mtvec=0x101; trap with mcause_in=0x8000_0007.
  - Response: redirect_pc=0x11C.
  - Then mret: redirect_pc=mepc, ret=1 for 1 cycle, MIE=1, MPIE=1, in_trap=0.
- CSR ops:
  - RW mscratch=0xF0F0, then RS 0x000F -> reads back 0xF0FF.
  - RC 0xF000 -> 0x00FF.
  - Write 0xFFFF_FFFF to mstatus -> reads 0x0000_1888.
  - Read 0x7C0 -> csr_rdata=0, csr_err=1.
- Collisions:
  - trap while in TRAP -> no redirect, mepc unchanged.
  - trap+mret in TRAP -> return only.
  - trap+mret in IDLE -> entry only.
- resetn pulsed low while in TRAP -> all outputs at reset values that cycle, state IDLE, no ret pulse.
